// File: rtl/div_ctrl_if.sv
// Handshake bundle between the execute stage, div_ctrl and the signed divider core.
// The slave modport is the div_ctrl side; master is the execute stage plus core side.
interface div_ctrl_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            req_valid_i;
    logic            req_ready_o;
    logic [2:0]      req_op_i;
    logic [XLEN-1:0] req_rs1_i;
    logic [XLEN-1:0] req_rs2_i;
    logic            resp_valid_o;
    logic            resp_ready_i;
    logic [XLEN-1:0] resp_data_o;
    logic            resp_err_o;
    logic [XLEN-1:0] div_a_o;
    logic [XLEN-1:0] div_b_o;
    logic            div_in_valid_o;
    logic            div_in_ready_i;
    logic [XLEN-1:0] div_c_i;
    logic            div_out_valid_i;
    logic            div_out_ready_o;

    modport slave (
        input  req_valid_i, req_op_i, req_rs1_i, req_rs2_i, resp_ready_i,
               div_in_ready_i, div_c_i, div_out_valid_i,
        output req_ready_o, resp_valid_o, resp_data_o, resp_err_o,
               div_a_o, div_b_o, div_in_valid_o, div_out_ready_o
    );

    modport master (
        output req_valid_i, req_op_i, req_rs1_i, req_rs2_i, resp_ready_i,
               div_in_ready_i, div_c_i, div_out_valid_i,
        input  req_ready_o, resp_valid_o, resp_data_o, resp_err_o,
               div_a_o, div_b_o, div_in_valid_o, div_out_ready_o
    );
endinterface

// File: rtl/div_ctrl.sv
// RISC-V DIV/REM sequencer in front of the handshaked signed divider core: resolves
// special cases locally, corrects core quotient artifacts, derives REM by shift-add multiply.
module div_ctrl #(
    parameter int unsigned XLEN = 32
) (
    input logic       clock,
    input logic       nreset,
    div_ctrl_if.slave bus
);
    localparam int unsigned     CW      = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2:0]      OP_DIV  = 3'b100;
    localparam logic [2:0]      OP_REM  = 3'b110;

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_CAPT, S_ACK, S_FIX, S_MUL, S_RESP
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic [XLEN-1:0] quo_q, quo_d, prod_q, prod_d, mcand_q, mcand_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            minfix_q, minfix_d;
    logic            req_ready_q, req_ready_d, resp_valid_q, resp_valid_d;
    logic            resp_err_q, resp_err_d, in_valid_q, in_valid_d, out_ready_q, out_ready_d;
    logic [XLEN-1:0] resp_data_q, resp_data_d, div_a_q, div_a_d, div_b_q, div_b_d;

    logic            is_div, is_rem;
    logic [XLEN-1:0] rs2_abs, quo_fix, prod_next;

    assign is_div    = (op_q == OP_DIV);
    assign is_rem    = (op_q == OP_REM);
    assign rs2_abs   = rs2_q[XLEN-1] ? (~rs2_q + ONE) : rs2_q;
    assign quo_fix   = rs2_q[XLEN-1] ? (quo_q + ONE) : (quo_q - ONE);
    assign prod_next = prod_q + (quo_q[0] ? mcand_q : '0);

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        quo_d        = quo_q;
        prod_d       = prod_q;
        mcand_d      = mcand_q;
        cnt_d        = cnt_q;
        minfix_d     = minfix_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_data_d  = resp_data_q;
        in_valid_d   = in_valid_q;
        out_ready_d  = out_ready_q;
        div_a_d      = div_a_q;
        div_b_d      = div_b_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid_i) begin
                    op_d        = bus.req_op_i;
                    rs1_d       = bus.req_rs1_i;
                    rs2_d       = bus.req_rs2_i;
                    req_ready_d = 1'b0;
                    state_d     = S_CHECK;
                end
            end
            S_CHECK: begin
                minfix_d   = 1'b0;
                resp_err_d = 1'b0;
                if (!is_div && !is_rem) begin
                    resp_data_d  = '0;
                    resp_err_d   = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end else if (rs2_q == '0) begin
                    resp_data_d  = is_div ? '1 : rs1_q;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end else if (rs1_q == MIN_VAL && rs2_q == '1) begin
                    resp_data_d  = is_div ? MIN_VAL : '0;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end else if (rs2_q == MIN_VAL) begin
                    quo_d = (rs1_q == MIN_VAL) ? ONE : '0;
                    if (is_div) begin
                        resp_data_d  = quo_d;
                        resp_valid_d = 1'b1;
                        state_d      = S_RESP;
                    end else begin
                        prod_d  = '0;
                        mcand_d = rs2_q;
                        cnt_d   = '0;
                        state_d = S_MUL;
                    end
                end else begin
                    // The core cannot take MIN as dividend; shift it toward zero and repair in FIX.
                    minfix_d   = (rs1_q == MIN_VAL);
                    div_a_d    = (rs1_q == MIN_VAL) ? (rs1_q + rs2_abs) : rs1_q;
                    div_b_d    = rs2_q;
                    in_valid_d = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!bus.div_in_ready_i) begin
                    in_valid_d = 1'b0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.div_out_valid_i) state_d = S_CAPT;
            end
            S_CAPT: begin
                // 0x80000000 from the core is its negative-zero artifact, never a real quotient.
                quo_d       = (bus.div_c_i == MIN_VAL) ? '0 : bus.div_c_i;
                out_ready_d = 1'b1;
                state_d     = S_ACK;
            end
            S_ACK: begin
                out_ready_d = 1'b0;
                if (minfix_q) begin
                    state_d = S_FIX;
                end else if (is_rem) begin
                    prod_d  = '0;
                    mcand_d = rs2_q;
                    cnt_d   = '0;
                    state_d = S_MUL;
                end else begin
                    resp_data_d  = quo_q;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_FIX: begin
                quo_d = quo_fix;
                if (is_rem) begin
                    prod_d  = '0;
                    mcand_d = rs2_q;
                    cnt_d   = '0;
                    state_d = S_MUL;
                end else begin
                    resp_data_d  = quo_fix;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_MUL: begin
                prod_d  = prod_next;
                quo_d   = quo_q >> 1;
                mcand_d = mcand_q << 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN - 1)) begin
                    resp_data_d  = rs1_q - prod_next;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            quo_q        <= '0;
            prod_q       <= '0;
            mcand_q      <= '0;
            cnt_q        <= '0;
            minfix_q     <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
            in_valid_q   <= 1'b0;
            out_ready_q  <= 1'b0;
            div_a_q      <= '0;
            div_b_q      <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            quo_q        <= quo_d;
            prod_q       <= prod_d;
            mcand_q      <= mcand_d;
            cnt_q        <= cnt_d;
            minfix_q     <= minfix_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_data_q  <= resp_data_d;
            in_valid_q   <= in_valid_d;
            out_ready_q  <= out_ready_d;
            div_a_q      <= div_a_d;
            div_b_q      <= div_b_d;
        end
    end

    assign bus.req_ready_o     = req_ready_q;
    assign bus.resp_valid_o    = resp_valid_q;
    assign bus.resp_data_o     = resp_data_q;
    assign bus.resp_err_o      = resp_err_q;
    assign bus.div_a_o         = div_a_q;
    assign bus.div_b_o         = div_b_q;
    assign bus.div_in_valid_o  = in_valid_q;
    assign bus.div_out_ready_o = out_ready_q;
endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: directed and random DIV/REM traffic against a RISC-V arithmetic
// reference, with a behavioural divider core that emits its negative-zero artifact.
module tb_div_ctrl;
    localparam logic [31:0] MIN_VAL = 32'h8000_0000;
    localparam logic [31:0] MAX_VAL = 32'h7FFF_FFFF;
    localparam logic [2:0]  OP_DIV  = 3'b100;
    localparam logic [2:0]  OP_REM  = 3'b110;

    logic clock = 1'b0;
    logic nreset = 1'b0;
    always #5 clock = ~clock;

    div_ctrl_if #(.XLEN(32)) bus ();
    div_ctrl #(.XLEN(32)) dut (.clock(clock), .nreset(nreset), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;
    int n_tmo    = 0;

    int          core_lat   = 2;
    logic        drv_lit_en = 1'b0;
    logic [32:0] drv_lit    = '0;
    logic        drv_a_en   = 1'b0;
    logic [31:0] drv_a_lit  = '0;

    // ---------------- behavioural divider core ----------------
    logic        c_in_ready, c_out_valid, c_settle;
    logic [31:0] c_c, c_res;
    int          c_cnt;

    // Sign-magnitude core: a zero magnitude with negative sign comes out as 0x80000000.
    function automatic logic [31:0] core_div(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb, mag;
        ma  = a[31] ? -a : a;
        mb  = b[31] ? -b : b;
        if (mb == 0) return '1;
        mag = ma / mb;
        if (a[31] ^ b[31]) return (mag == 0) ? MIN_VAL : -mag;
        return mag;
    endfunction

    always @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            c_in_ready  <= 1'b1;
            c_out_valid <= 1'b0;
            c_settle    <= 1'b0;
            c_c         <= '0;
            c_res       <= '0;
            c_cnt       <= 0;
        end else if (c_in_ready) begin
            if (bus.div_in_valid_o) begin
                c_in_ready <= 1'b0;
                c_cnt      <= core_lat;
                c_res      <= core_div(bus.div_a_o, bus.div_b_o);
            end
        end else if (!c_out_valid) begin
            if (c_cnt == 0) begin
                c_out_valid <= 1'b1;
                c_c         <= $urandom;
                c_settle    <= 1'b1;
            end else begin
                c_cnt <= c_cnt - 1;
            end
        end else begin
            if (c_settle) begin
                c_c      <= c_res;
                c_settle <= 1'b0;
            end
            if (bus.div_out_ready_o) begin
                c_out_valid <= 1'b0;
                c_in_ready  <= 1'b1;
            end
        end
    end

    assign bus.div_in_ready_i  = c_in_ready;
    assign bus.div_out_valid_i = c_out_valid;
    assign bus.div_c_i         = c_c;

    // ---------------- reference model ----------------
    function automatic logic [32:0] ref_result(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (op != OP_DIV && op != OP_REM) return {1'b1, 32'h0};
        if (y == 0) return {1'b0, (op == OP_DIV) ? 32'hFFFF_FFFF : x};
        r = (op == OP_DIV) ? sx / sy : sx % sy;
        return {1'b0, r[31:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- compare process ----------------
    logic        busy = 1'b0;
    logic        m_core, m_fix, m_rem, m_special, ov_seen, m_lit_en, m_a_en;
    logic [32:0] m_exp, m_lit;
    logic [31:0] m_a, m_b, m_a_lit, mx, my;
    logic [2:0]  mop;
    int          cnt, k, m_lat, n_acc;

    always @(negedge clock) begin
        if (!nreset) begin
            chk("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
            chk("rst_outputs", {bus.resp_valid_o, bus.resp_err_o, bus.div_in_valid_o, bus.div_out_ready_o,
                                bus.resp_data_o, bus.div_a_o | bus.div_b_o}, 64'd0);
            busy = 1'b0;
        end else if (busy) begin
            cnt++;
            if (ov_seen) k++;
            else if (bus.div_out_valid_i) begin
                ov_seen = 1'b1;
                k = 0;
            end
            chk("req_ready_busy", 64'(bus.req_ready_o), 64'd0);
            chk("resp_valid", 64'(bus.resp_valid_o),
                64'(m_core ? (ov_seen && k >= m_lat) : (cnt >= m_lat)));
            if (bus.resp_valid_o)
                chk("resp_data_err", 64'({bus.resp_err_o, bus.resp_data_o}), 64'(m_exp));
            chk("out_ready_pulse", 64'(bus.div_out_ready_o), 64'(m_core && ov_seen && k == 2));
            if (!m_core) chk("no_core_in_valid", 64'(bus.div_in_valid_o), 64'd0);
            if (bus.div_in_valid_o && bus.div_in_ready_i) begin
                n_acc++;
                chk("core_a", 64'(bus.div_a_o), 64'(m_a));
                chk("core_b", 64'(bus.div_b_o), 64'(m_b));
                if (m_a_en) chk("core_a_literal", 64'(bus.div_a_o), 64'(m_a_lit));
            end
            if (bus.resp_valid_o && bus.resp_ready_i) begin
                chk("core_handshakes", 64'(n_acc), 64'(m_core ? 1 : 0));
                if (m_lit_en) chk("literal_result", 64'({bus.resp_err_o, bus.resp_data_o}), 64'(m_lit));
                busy = 1'b0;
            end
        end else begin
            chk("idle_outputs", {bus.req_ready_o, bus.resp_valid_o, bus.div_in_valid_o, bus.div_out_ready_o}, 64'h8);
            if (bus.req_valid_i && bus.req_ready_o) begin
                mop       = bus.req_op_i;
                mx        = bus.req_rs1_i;
                my        = bus.req_rs2_i;
                m_exp     = ref_result(mop, mx, my);
                m_rem     = (mop == OP_REM);
                m_special = m_exp[32] || my == 0 || (mx == MIN_VAL && my == '1);
                m_core    = !m_special && my != MIN_VAL;
                m_fix     = m_core && mx == MIN_VAL;
                m_a       = (mx == MIN_VAL) ? mx + (my[31] ? -my : my) : mx;
                m_b       = my;
                if (m_core) m_lat = 3 + (m_fix ? 1 : 0) + (m_rem ? 32 : 0);
                else        m_lat = 2 + ((!m_special && m_rem) ? 32 : 0);
                m_lit_en  = drv_lit_en;
                m_lit     = drv_lit;
                m_a_en    = drv_a_en;
                m_a_lit   = drv_a_lit;
                busy      = 1'b1;
                cnt       = 0;
                k         = 0;
                ov_seen   = 1'b0;
                n_acc     = 0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_req(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        int t = 0;
        while (!bus.req_ready_o && t < 400) begin
            tick();
            t++;
        end
        if (!bus.req_ready_o) begin
            n_tmo++;
            $display("FAIL req_ready_timeout: req_ready 0 after %0d cycles, want 1", t);
        end
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = op;
        bus.req_rs1_i   = x;
        bus.req_rs2_i   = y;
        tick();
        bus.req_valid_i = 1'b0;
        bus.req_op_i    = 3'($urandom);
        bus.req_rs1_i   = $urandom;
        bus.req_rs2_i   = $urandom;
    endtask

    task automatic run_txn(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                           input int hold, input logic lit_en, input logic [32:0] lit);
        int t = 0;
        drv_lit_en = lit_en;
        drv_lit    = lit;
        send_req(op, x, y);
        while (!bus.resp_valid_o && t < 400) begin
            tick();
            t++;
        end
        if (!bus.resp_valid_o) begin
            n_tmo++;
            $display("FAIL resp_timeout: resp_valid 0 after %0d cycles, want 1", t);
        end
        repeat (hold) tick();
        bus.resp_ready_i = 1'b1;
        tick();
        bus.resp_ready_i = 1'b0;
        drv_lit_en = 1'b0;
        drv_a_en   = 1'b0;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return MIN_VAL;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            4: return MAX_VAL;
            5: return 32'($urandom_range(0, 200)) - 32'd100;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [2:0] rop;
        bus.req_valid_i  = 1'b0;
        bus.req_op_i     = '0;
        bus.req_rs1_i    = '0;
        bus.req_rs2_i    = '0;
        bus.resp_ready_i = 1'b0;
        repeat (3) tick();
        nreset = 1'b1;
        tick();

        run_txn(OP_DIV, 32'd100, 32'd7, 0, 1'b1, {1'b0, 32'd14});
        run_txn(OP_REM, 32'hFFFF_FF9C, 32'd7, 1, 1'b1, {1'b0, 32'hFFFF_FFFE});
        run_txn(OP_DIV, 32'hFFFF_FF9C, 32'd7, 0, 1'b1, {1'b0, 32'hFFFF_FFF2});
        run_txn(OP_DIV, 32'd1, 32'hFFFF_FFFE, 0, 1'b1, {1'b0, 32'd0});
        run_txn(OP_REM, 32'd1, 32'hFFFF_FFFE, 0, 1'b1, {1'b0, 32'd1});
        run_txn(OP_DIV, 32'd12345, 32'd0, 0, 1'b1, {1'b0, 32'hFFFF_FFFF});
        run_txn(OP_REM, 32'd5, 32'd0, 0, 1'b1, {1'b0, 32'd5});
        run_txn(OP_DIV, MIN_VAL, 32'hFFFF_FFFF, 0, 1'b1, {1'b0, MIN_VAL});
        run_txn(OP_REM, MIN_VAL, 32'hFFFF_FFFF, 0, 1'b1, {1'b0, 32'd0});
        drv_a_en  = 1'b1;
        drv_a_lit = 32'h8000_0003;
        run_txn(OP_DIV, MIN_VAL, 32'd3, 0, 1'b1, {1'b0, 32'hD555_5556});
        run_txn(OP_REM, MIN_VAL, 32'd3, 0, 1'b1, {1'b0, 32'hFFFF_FFFE});
        run_txn(OP_DIV, MIN_VAL, MIN_VAL, 0, 1'b1, {1'b0, 32'd1});
        run_txn(3'b101, 32'd10, 32'd3, 0, 1'b1, {1'b1, 32'd0});
        run_txn(OP_DIV, 32'd100, 32'd7, 5, 1'b1, {1'b0, 32'd14});

        // Reset while the controller waits on a slow core.
        core_lat = 20;
        send_req(OP_DIV, 32'd50, 32'd7);
        repeat (8) tick();
        nreset = 1'b0;
        repeat (2) tick();
        nreset = 1'b1;
        core_lat = 2;
        tick();
        run_txn(OP_DIV, 32'd9, 32'd3, 0, 1'b1, {1'b0, 32'd3});

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                0: rop = 3'($urandom);
                1, 2, 3, 4: rop = OP_DIV;
                default: rop = OP_REM;
            endcase
            core_lat = $urandom_range(0, 6);
            run_txn(rop, pick_val(), pick_val(), $urandom_range(0, 3), 1'b0, '0);
        end

        repeat (4) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks + n_tmo);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end
endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencing front-end for the handshaked signed divider core (32-bit operands in a/b, 32-bit quotient out on c); sits directly upstream of it, between the execute stage and the core.
- Accepts RISC-V DIV/REM requests and resolves architectural special cases without the core.
- Drives the core's valid/ready handshake, corrects quotient edge cases, and derives the remainder with an internal shift-add multiplier.

Parameters:
- XLEN, 32, operand and result width; only 32 is supported.

Ports:
- clock  in  1  system clock; all block state updates on posedge.
- nreset  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  block idle, can accept a request.
- req_op_i  in  3  funct3: 100=DIV, 110=REM; any other code is unsupported.
- req_rs1_i  in  32  dividend.
- req_rs2_i  in  32  divisor.
- resp_valid_o  out  1  result valid.
- resp_ready_i  in  1  result consumed.
- resp_data_o  out  32  quotient or remainder.
- resp_err_o  out  1  unsupported op.
- div_a_o  out  32  core dividend.
- div_b_o  out  32  core divisor.
- div_in_valid_o  out  1  to core in_valid_i.
- div_in_ready_i  in  1  from core in_ready_o.
- div_c_i  in  32  from core c.
- div_out_valid_i  in  1  from core out_valid_o.
- div_out_ready_o  out  1  to core out_ready_i.

Behaviour:
- Reset values: req_ready_o=1; all other outputs 0; FSM=IDLE. Reset mid-operation aborts immediately.
- FSM states: IDLE, CHECK, ISSUE, WAIT, CAPT, ACK, FIX, MUL, RESP.
- IDLE: req_ready_o=1. When req_valid_i=1, latch op/rs1/rs2 and go to CHECK.
- CHECK (1 cycle, all results registered, then RESP):
  - Unsupported op: result 0, err=1.
  - rs2==0: DIV returns 0xFFFFFFFF; REM returns rs1.
  - rs1==0x80000000 and rs2==0xFFFFFFFF: DIV returns 0x80000000; REM returns 0.
  - rs2==0x80000000: quotient = (rs1==0x80000000) ? 1 : 0.
  - Otherwise go to ISSUE.
  - Dividend substitution: if rs1==0x80000000, div_a_o = rs1 + |rs2| (set flag MINFIX); else div_a_o = rs1. div_b_o = rs2.
- ISSUE: div_in_valid_o=1. Hold until div_in_ready_i=0 is sampled (core has left its idle state), then go to WAIT with div_in_valid_o=0.
- WAIT: wait for div_out_valid_i=1, then go to CAPT. div_out_ready_o stays 0 so the core holds in its done state.
- CAPT: sample div_c_i into q. The core's c register settles one posedge after out_valid rises.
  - Force q=0 if div_c_i==0x80000000. This is a core artifact for negative zero; a legitimate 0x80000000 quotient never reaches the core.
- ACK: div_out_ready_o=1 for exactly one cycle, div_in_valid_o=0.
  - Go to FIX if MINFIX is set, otherwise MUL (REM) or RESP (DIV).
- FIX: q = q - sign(rs2), i.e. q+1 if rs2<0, else q-1. Then go to MUL (REM) or RESP (DIV).
- MUL (REM only):
  - 32-cycle shift-add computing p = q*rs2, low 32 bits.
  - Result r = rs1 - p, modulo 2^32.
  - Remainder sign always equals the dividend sign (or is 0).
  - Also used after the rs2==0x80000000 bypass, so REM there gives rs1 - q*rs2.
- RESP: resp_valid_o=1; resp_data_o/resp_err_o stable until the resp_ready_i handshake, then IDLE. req_ready_o=0 in every state except IDLE.
- Latency from request acceptance:
  - Bypassed DIV: 2 cycles to resp_valid.
  - Core DIV: issue + core time + 3.
  - REM: add 32 cycles.

Test Plan:
- DIV rs1=100, rs2=7 -> resp_data=14, err=0; core handshake seen exactly once; div_out_ready one-cycle pulse.
- REM rs1=-100 (0xFFFFFF9C), rs2=7 -> resp_data=0xFFFFFFFE (-2); DIV same operands -> 0xFFFFFFF2 (-14).
- DIV rs1=1, rs2=-2 -> 0 (core's 0x80000000 masked); REM same -> 1.
- Special cases:
  - DIV x/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
  - Core never requested in any of these.
- DIV 0x80000000/3 -> core sees a=0x80000003, final 0xD5555556; REM -> 0xFFFFFFFE. DIV 0x80000000/0x80000000 -> 1.
- op=101 -> err=1, data=0. Reset asserted in WAIT -> outputs at reset values next cycle; a new DIV 9/3 then returns 3. resp_ready_i held low 5 cycles -> data held stable.
